beat_generator: RTL
===================

// Module: beat_generator
// PURPOSE
//  Produces the song-tempo beat strobe (beat_clk) consumed by the beat-counting/finish logic.
//  Divides clk down to one single-cycle pulse per beat at a selected tempo.
//  Runs a count-in of metronome clicks first, then streams beats.
//  Supports pause and resume, and stops when the downstream counter raises finish.
// PARAMETERS
//  DIV0          5_000_000  clk cycles per beat, tempo_sel=0 (120 BPM @10 MHz)
//  DIV1          6_666_667  clk cycles per beat, tempo_sel=1 (90 BPM)
//  DIV2          4_000_000  clk cycles per beat, tempo_sel=2 (150 BPM)
//  DIV3          3_333_333  clk cycles per beat, tempo_sel=3 (180 BPM)
//  CNT_W         24         phase counter width; every DIVn must satisfy 2 <= DIVn < 2**CNT_W
//  COUNTIN_BEATS 4          count-in clicks before play; 0 = skip the count-in
// PORTS
//  clk        in   1  system clock
//  n_rst      in   1  asynchronous active-low reset
//  start      in   1  one-cycle start request
//  pause      in   1  level; high freezes beat timing while in PLAY
//  tempo_sel  in   2  tempo preset; sampled only on an accepted start
//  finish     in   1  from the beat/finish counter; ends the song
//  beat_clk   out  1  one-cycle beat strobe, PLAY only
//  click      out  1  one-cycle count-in strobe, COUNT_IN only
//  playing    out  1  high in PLAY and PAUSED
//  done       out  1  high in DONE
//  beat_num   out  6  beats emitted since start; saturates at 63
// BEHAVIOUR
//  Clock and reset
//   - One clock. Reset is async, active-low.
//   - Reset puts the FSM in IDLE, clears phase, clears the count-in count, and drives all outputs to 0.
//   - Reset in mid-song aborts the song immediately. No state is retained.
//  FSM states: IDLE, COUNT_IN, PLAY, PAUSED, DONE.
//  Start
//   - start is accepted only in IDLE or DONE. It is ignored in every other state.
//   - An accepted start latches tempo_sel into tempo_q, clears phase and beat_num, and moves to
//     COUNT_IN (or to PLAY when COUNTIN_BEATS=0).
//  Tempo divider
//   - div = DIV[tempo_q]. tempo_q is constant for the whole song.
//   - phase counts 0..div-1 while enabled (COUNT_IN or PLAY), then wraps to 0.
//   - tick is asserted combinationally when phase == div-1 and the divider is enabled.
//   - phase is cleared on every state entry, except PAUSED -> PLAY, which resumes from the
//     frozen phase.
//  Strobes
//   - click, beat_clk and done are registered: each is high in the cycle after its tick or
//     state change.
//   - First click appears div cycles after start is sampled (start seen at edge 0 -> click high
//     at edge div+1). Clicks then repeat every div cycles.
//  Count-in
//   - The tick that produces the COUNTIN_BEATS-th click also moves the FSM to PLAY.
//   - First beat_clk follows the last click by exactly div cycles.
//   - beat_clk then repeats every div cycles.
//  PLAY
//   - Each tick pulses beat_clk and increments beat_num (saturates at 63).
//   - Priority within one cycle: finish > pause > tick.
//   - pause=1 -> PAUSED. phase holds, no strobe, beat_num holds.
//  PAUSED
//   - pause=0 -> PLAY. The next beat arrives div - phase_frozen cycles after resume.
//   - finish=1 -> DONE.
//  Finish
//   - finish=1 in PLAY or PAUSED -> DONE. No beat_clk is emitted in that cycle, even on a tick.
//   - finish is ignored in IDLE, COUNT_IN and DONE.
//  DONE
//   - done=1 and playing=0. beat_num holds its final value until the next accepted start.
//  Simultaneous events
//   - start together with pause or finish while in IDLE or DONE: start wins.
//   - In COUNT_IN, pause is ignored; the count-in always completes.
// STRUCTURE
//  Package beat_gen_pkg holds:
//   - state_t enum {IDLE, COUNT_IN, PLAY, PAUSED, DONE}
//   - tempo_t (logic [1:0])
//   - default DIVn constants and the BEAT_NUM_MAX=63 constant
//  Sub-module beat_tick_divider
//   - Parameterised by CNT_W.
//   - Ports: clk, n_rst, en, clr, div, tick.
//   - Contains the phase counter with wrap at div-1.
//  Top level holds:
//   - the FSM
//   - the count-in counter
//   - tempo_q, beat_num
//   - the output registers
// TESTING  (bench overrides DIV0=10, DIV1=8, DIV2=6, DIV3=4; COUNTIN_BEATS=4)
//  1. Reset: hold n_rst=0 -> all outputs 0. Release with no start for 100 cycles -> outputs stay 0.
//  2. Basic song: start at edge 0 with tempo_sel=0 -> click at edges 11, 21, 31, 41;
//     beat_clk at 51, 61, 71...; beat_num=3 after edge 71.
//  3. Tempo latch: start with tempo_sel=3, then change tempo_sel to 0 mid-song
//     -> beat_clk spacing stays 4 cycles.
//  4. Pause: DIV0=10, assert pause 3 cycles after a beat_clk and hold it 20 cycles
//     -> no beat_clk while paused; next beat_clk exactly 7 cycles after pause falls.
//  5. Finish priority: assert finish in the same cycle as a tick -> no beat_clk;
//     done=1 next cycle; playing=0. Then start -> COUNT_IN and beat_num=0.
//  6. Edge cases:
//     - start pulsed during PLAY -> ignored.
//     - n_rst pulsed during PAUSED -> IDLE with all outputs 0.
//     - COUNTIN_BEATS=0 build: first beat_clk at edge 11 after start.

Source files
------------

// File: rtl/beat_gen_pkg.sv
// Shared types, default tempo dividers and beat-count helpers for the beat generator.
package beat_gen_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COUNT_IN = 3'd1,
      PLAY     = 3'd2,
      PAUSED   = 3'd3,
      DONE     = 3'd4
   } state_t;

   typedef logic [1:0] tempo_t;

   // clk cycles per beat at 10 MHz: 120, 90, 150 and 180 BPM
   localparam int unsigned DIV0_DEFAULT    = 32'd5_000_000;
   localparam int unsigned DIV1_DEFAULT    = 32'd6_666_667;
   localparam int unsigned DIV2_DEFAULT    = 32'd4_000_000;
   localparam int unsigned DIV3_DEFAULT    = 32'd3_333_333;
   localparam int unsigned COUNTIN_DEFAULT = 32'd4;
   localparam logic [5:0]  BEAT_NUM_MAX    = 6'd63;

   function automatic logic [5:0] beat_num_next(input logic [5:0] n);
      beat_num_next = (n == BEAT_NUM_MAX) ? n : (n + 6'd1);
   endfunction

endpackage

// File: rtl/beat_tick_divider.sv
// Phase counter running 0..div-1 while enabled; tick flags the wrap cycle.
module beat_tick_divider #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(32'd1);

   logic [CNT_W-1:0] phase_r;

   assign tick = en && (phase_r == (div - ONE));

   // phase holds while disabled so a paused song resumes mid-beat
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         phase_r <= '0;
      end else if (clr) begin
         phase_r <= '0;
      end else if (tick) begin
         phase_r <= '0;
      end else if (en) begin
         phase_r <= phase_r + ONE;
      end else begin
         phase_r <= phase_r;
      end
   end

endmodule

// File: rtl/beat_generator.sv
// Song tempo strobe: count-in clicks, then beats, with pause/resume and finish.
module beat_generator
   import beat_gen_pkg::*;
#(
   parameter int unsigned DIV0          = DIV0_DEFAULT,
   parameter int unsigned DIV1          = DIV1_DEFAULT,
   parameter int unsigned DIV2          = DIV2_DEFAULT,
   parameter int unsigned DIV3          = DIV3_DEFAULT,
   parameter int          CNT_W         = 24,
   parameter int unsigned COUNTIN_BEATS = COUNTIN_DEFAULT
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       pause,
   input  logic [1:0] tempo_sel,
   input  logic       finish,
   output logic       beat_clk,
   output logic       click,
   output logic       playing,
   output logic       done,
   output logic [5:0] beat_num
);

   localparam int CI_W = (COUNTIN_BEATS > 32'd1) ? $clog2(COUNTIN_BEATS) : 1;
   localparam logic [CI_W-1:0] CI_LAST =
      (COUNTIN_BEATS > 32'd0) ? CI_W'(COUNTIN_BEATS - 32'd1) : '0;
   localparam logic [CI_W-1:0] CI_ONE = CI_W'(32'd1);

   state_t           state_r;
   tempo_t           tempo_q_r;
   logic [5:0]       beat_num_r;
   logic [CI_W-1:0]  ci_cnt_r;
   logic             click_r;
   logic             beat_clk_r;
   logic             playing_r;
   logic             done_r;
   logic [CNT_W-1:0] div_s;
   logic             en_s;
   logic             clr_s;
   logic             tick_s;

   // divider length for the tempo latched at start
   always_comb begin
      div_s = CNT_W'(DIV0);
      case (tempo_q_r)
         2'd0:    div_s = CNT_W'(DIV0);
         2'd1:    div_s = CNT_W'(DIV1);
         2'd2:    div_s = CNT_W'(DIV2);
         2'd3:    div_s = CNT_W'(DIV3);
         default: div_s = CNT_W'(DIV0);
      endcase
   end

   // pause only freezes the divider in PLAY; entering PAUSED keeps the phase
   always_comb begin
      en_s  = 1'b0;
      clr_s = 1'b0;
      case (state_r)
         IDLE, DONE: clr_s = start;
         COUNT_IN:   en_s  = 1'b1;
         PLAY: begin
            en_s  = !finish && !pause;
            clr_s = finish;
         end
         PAUSED:     clr_s = finish;
         default:    clr_s = 1'b1;
      endcase
   end

   beat_tick_divider #(
      .CNT_W (CNT_W)
   ) u_divider (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (en_s),
      .clr   (clr_s),
      .div   (div_s),
      .tick  (tick_s)
   );

   // song FSM with registered strobes and status
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r    <= IDLE;
         tempo_q_r  <= 2'd0;
         beat_num_r <= 6'd0;
         ci_cnt_r   <= '0;
         click_r    <= 1'b0;
         beat_clk_r <= 1'b0;
         playing_r  <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         click_r    <= 1'b0;
         beat_clk_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  tempo_q_r  <= tempo_sel;
                  beat_num_r <= 6'd0;
                  ci_cnt_r   <= '0;
                  done_r     <= 1'b0;
                  if (COUNTIN_BEATS == 32'd0) begin
                     state_r   <= PLAY;
                     playing_r <= 1'b1;
                  end else begin
                     state_r   <= COUNT_IN;
                     playing_r <= 1'b0;
                  end
               end
            end
            COUNT_IN: begin
               if (tick_s) begin
                  click_r <= 1'b1;
                  if (ci_cnt_r == CI_LAST) begin
                     ci_cnt_r  <= '0;
                     state_r   <= PLAY;
                     playing_r <= 1'b1;
                  end else begin
                     ci_cnt_r <= ci_cnt_r + CI_ONE;
                  end
               end
            end
            PLAY: begin
               if (finish) begin
                  state_r   <= DONE;
                  playing_r <= 1'b0;
                  done_r    <= 1'b1;
               end else if (pause) begin
                  state_r <= PAUSED;
               end else if (tick_s) begin
                  beat_clk_r <= 1'b1;
                  beat_num_r <= beat_num_next(beat_num_r);
               end
            end
            PAUSED: begin
               if (finish) begin
                  state_r   <= DONE;
                  playing_r <= 1'b0;
                  done_r    <= 1'b1;
               end else if (!pause) begin
                  state_r <= PLAY;
               end
            end
            default: begin
               state_r   <= IDLE;
               playing_r <= 1'b0;
               done_r    <= 1'b0;
            end
         endcase
      end
   end

   assign beat_clk = beat_clk_r;
   assign click    = click_r;
   assign playing  = playing_r;
   assign done     = done_r;
   assign beat_num = beat_num_r;

endmodule
